// File: rtl/fifo_pkg.sv
// fifo_pkg: types shared by the FIFO-side blocks
package fifo_pkg;
    typedef enum logic [1:0] {EMPTY, HOLD, CLOSE} state_t;
endpackage

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a valid/ready FIFO into framed first/last bursts
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 8,
    parameter int TIMEOUT    = 16,
    parameter int CW         = $clog2(BURST_LEN),
    parameter int TW         = $clog2(TIMEOUT + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_fifo_valid,
    output logic                  o_fifo_ready,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_flush,
    output logic                  o_valid_m,
    input  logic                  i_ready_m,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_first,
    output logic                  o_last,
    output logic                  o_busy
);
    state_t          state, state_nxt;
    logic [CW-1:0]   beat_cnt;
    logic [TW-1:0]   idle_cnt;
    logic            hold_vld, hs, pop, timeout, close_req;

    assign hold_vld     = state != EMPTY;
    assign o_last       = hold_vld & ((beat_cnt == CW'(BURST_LEN - 1)) | (state == CLOSE));
    assign o_first      = hold_vld & (beat_cnt == '0);
    assign o_valid_m    = hold_vld & (i_fifo_valid | o_last);
    assign hs           = o_valid_m & i_ready_m;
    assign o_fifo_ready = ~hold_vld | hs;
    assign pop          = i_fifo_valid & o_fifo_ready;
    assign timeout      = (idle_cnt == TW'(TIMEOUT - 1)) & ~i_fifo_valid;
    // a beat already offered as non-last cannot be re-marked last, so a close is refused then
    assign close_req    = (timeout | i_flush) & (~o_valid_m | o_last);
    assign o_busy       = hold_vld | (beat_cnt != '0);

    // next state: refill or drain whenever the holding register frees up, else close on request
    always_comb begin
        state_nxt = o_fifo_ready ? (i_fifo_valid ? HOLD : EMPTY)
                  : (state == HOLD && close_req) ? CLOSE : state;
    end

    // holding register, beat counter and idle counter
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= EMPTY;
            beat_cnt <= '0;
            idle_cnt <= '0;
            o_data   <= '0;
        end else begin
            state <= state_nxt;
            if (pop)
                o_data <= i_fifo_data;
            if (hs)
                beat_cnt <= o_last ? '0 : beat_cnt + CW'(1);
            idle_cnt <= (pop || state != HOLD || state_nxt != HOLD) ? '0
                      : (!i_fifo_valid && idle_cnt != TW'(TIMEOUT - 1)) ? idle_cnt + TW'(1)
                      : idle_cnt;
        end
    end
endmodule
